// File: rtl/psum_route_net_if.sv
// Psum routing fabric bus: PE array links, external psum feed, tap FIFO
// heads and the configuration handshake, bundled for psum_route_net.
interface psum_route_net_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int DW   = 16
);
  localparam int RC  = ROWS * COLS;
  localparam int SLW = $clog2(ROWS + 1);

  logic [RC-1:0]      pe_out_valid;
  logic [RC*DW-1:0]   pe_out_data;
  logic [RC-1:0]      pe_out_ack;
  logic [RC-1:0]      pe_in_valid;
  logic [RC*DW-1:0]   pe_in_data;
  logic [RC-1:0]      pe_in_ack;
  logic [COLS-1:0]    ext_valid;
  logic [COLS*DW-1:0] ext_data;
  logic [COLS-1:0]    ext_ack;
  logic [RC-1:0]      tap_valid;
  logic [RC*DW-1:0]   tap_data;
  logic [RC-1:0]      tap_ack;
  logic               cfg_req;
  logic [SLW-1:0]     cfg_seg_len;
  logic               cfg_ext_en;
  logic               cfg_busy;
  logic               cfg_ack;
  logic               cfg_err;
  logic [SLW-1:0]     seg_len;
  logic               ext_en;

  // PE array, psum/output buffers and configuration master
  modport master (
    output pe_out_valid, pe_out_data, pe_in_ack, ext_valid, ext_data, tap_ack,
           cfg_req, cfg_seg_len, cfg_ext_en,
    input  pe_out_ack, pe_in_valid, pe_in_data, ext_ack, tap_valid, tap_data,
           cfg_busy, cfg_ack, cfg_err, seg_len, ext_en
  );

  // Routing fabric
  modport slave (
    input  pe_out_valid, pe_out_data, pe_in_ack, ext_valid, ext_data, tap_ack,
           cfg_req, cfg_seg_len, cfg_ext_en,
    output pe_out_ack, pe_in_valid, pe_in_data, ext_ack, tap_valid, tap_data,
           cfg_busy, cfg_ack, cfg_err, seg_len, ext_en
  );
endinterface

// File: rtl/psum_route_net.sv
// Runtime-segmented psum routing fabric. The PE array is cut into vertical
// segments of seg_len rows; segment tops are fed zeros (or the external psum
// stream for row 0), segment bottoms drain into per-PE tap FIFOs. A config
// change drains every FIFO and in-flight PE output before it is applied.
module psum_route_net #(
  parameter int ROWS       = 6,
  parameter int COLS       = 7,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  psum_route_net_if.slave bus
);
  localparam int RC  = ROWS * COLS;
  localparam int SLW = $clog2(ROWS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

  state_t         state_q, state_d;
  logic [SLW-1:0] seg_len_q, seg_len_d, req_len_q, req_len_d;
  logic           ext_en_q, ext_en_d, req_ext_q, req_ext_d;
  logic           cfg_err_q, cfg_err_d;

  logic [DW-1:0]  mem_q [RC][FIFO_DEPTH];
  logic [AW-1:0]  wp_q  [RC];
  logic [AW-1:0]  rp_q  [RC];
  logic [CW-1:0]  cnt_q [RC];

  logic [ROWS-1:0] top, bot;
  logic [RC-1:0]   push, pop;
  logic            fifos_empty, src_on, legal_req;

  // Sources feed PEs only in RUN and never while reset is held
  assign src_on = (state_q == RUN) && !rst;

  // Segment top/bottom flags: walk the rows with a position-in-segment counter
  always_comb begin
    logic [SLW-1:0] pos;
    pos = '0;
    top = '0;
    bot = '0;
    for (int r = 0; r < ROWS; r++) begin
      top[r] = (pos == '0);
      bot[r] = (pos == seg_len_q - 1'b1) || (r == ROWS - 1);
      pos    = (pos == seg_len_q - 1'b1) ? '0 : pos + 1'b1;
    end
  end

  // Psum routing: interior links, segment-top sources, bottom-row FIFO acks/taps
  always_comb begin
    bus.pe_in_valid = '0;
    bus.pe_in_data  = '0;
    bus.pe_out_ack  = '0;
    bus.ext_ack     = '0;
    bus.tap_valid   = '0;
    bus.tap_data    = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bot[r]) begin
          bus.pe_out_ack[r*COLS+c] = (cnt_q[r*COLS+c] < CW'(FIFO_DEPTH)) && (state_q != APPLY);
          bus.tap_valid[r*COLS+c]  = (cnt_q[r*COLS+c] != '0);
          bus.tap_data[(r*COLS+c)*DW +: DW] = mem_q[r*COLS+c][rp_q[r*COLS+c]];
        end
        if (top[r]) begin
          if (r == 0 && ext_en_q) begin
            bus.pe_in_valid[c]          = bus.ext_valid[c] && src_on;
            bus.pe_in_data[c*DW +: DW]  = bus.ext_data[c*DW +: DW];
            bus.ext_ack[c]              = bus.pe_in_ack[c] && src_on;
          end else begin
            bus.pe_in_valid[r*COLS+c]   = src_on;
          end
        end
      end
    end
    for (int r = 1; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!top[r]) begin
          bus.pe_in_valid[r*COLS+c] = bus.pe_out_valid[(r-1)*COLS+c];
          bus.pe_in_data[(r*COLS+c)*DW +: DW] = bus.pe_out_data[((r-1)*COLS+c)*DW +: DW];
          bus.pe_out_ack[(r-1)*COLS+c] = bus.pe_in_ack[r*COLS+c];
        end
      end
    end
  end

  // FIFO push/pop strobes and the global empty flag used by DRAIN
  always_comb begin
    push        = '0;
    pop         = '0;
    fifos_empty = 1'b1;
    for (int i = 0; i < RC; i++) begin
      push[i] = bus.pe_out_valid[i] && bus.pe_out_ack[i] && bot[i / COLS];
      pop[i]  = bus.tap_valid[i] && bus.tap_ack[i];
      if (cnt_q[i] != '0) fifos_empty = 1'b0;
    end
  end

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < RC; i++) begin
      if (push[i]) mem_q[i][wp_q[i]] <= bus.pe_out_data[i*DW +: DW];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RC; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RC; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Config FSM next state: latch legal requests, drain, apply for one cycle
  always_comb begin
    state_d   = state_q;
    seg_len_d = seg_len_q;
    ext_en_d  = ext_en_q;
    req_len_d = req_len_q;
    req_ext_d = req_ext_q;
    cfg_err_d = 1'b0;
    legal_req = (bus.cfg_seg_len != '0) && (bus.cfg_seg_len <= SLW'(ROWS));
    case (state_q)
      RUN: begin
        if (bus.cfg_req) begin
          if (legal_req) begin
            req_len_d = bus.cfg_seg_len;
            req_ext_d = bus.cfg_ext_en;
            state_d   = DRAIN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (fifos_empty && (bus.pe_out_valid == '0)) state_d = APPLY;
      end
      APPLY: begin
        seg_len_d = req_len_q;
        ext_en_d  = req_ext_q;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Config FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      seg_len_q <= SLW'(ROWS);
      ext_en_q  <= 1'b0;
      req_len_q <= SLW'(ROWS);
      req_ext_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_len_q <= seg_len_d;
      ext_en_q  <= ext_en_d;
      req_len_q <= req_len_d;
      req_ext_q <= req_ext_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.cfg_busy = (state_q != RUN);
  assign bus.cfg_ack  = (state_q == APPLY);
  assign bus.cfg_err  = cfg_err_q;
  assign bus.seg_len  = seg_len_q;
  assign bus.ext_en   = ext_en_q;
endmodule

// File: tb/tb_psum_route_net.sv
// Bench for psum_route_net: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_psum_route_net;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int DW   = 16;
  localparam int FD   = 2;
  localparam int RC   = ROWS * COLS;
  localparam int W    = RC * DW;

  logic clk, rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;

  psum_route_net_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();
  psum_route_net #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] q [RC][$];
  int  m_seg = ROWS, m_ext = 0, m_mode = 0, m_req_seg = ROWS, m_req_ext = 0;
  bit  m_err = 0;
  bit  s_rst = 1, s_req = 0, s_rext = 0, s_drain_ok = 0;
  int  s_rlen = 0;
  logic [RC-1:0]   m_push, m_pop;
  logic [DW-1:0]   m_pd [RC];

  always @(negedge clk) begin
    logic [RC-1:0]   e_iv, e_oack, e_tv;
    logic [W-1:0]    e_id, e_td, dm_i, dm_t;
    logic [COLS-1:0] e_eack;
    bit run, top, bot;
    int i;
    run = (m_mode == 0) && !rst;
    e_iv = '0; e_oack = '0; e_tv = '0; e_id = '0; e_td = '0;
    dm_i = '0; dm_t = '0; e_eack = '0; m_push = '0; m_pop = '0;
    s_drain_ok = (bus.pe_out_valid == '0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        i   = r * COLS + c;
        top = (r % m_seg) == 0;
        bot = (((r + 1) % m_seg) == 0) || (r == ROWS - 1);
        if (q[i].size() != 0) s_drain_ok = 0;
        if (bot) begin
          e_oack[i] = (q[i].size() < FD) && (m_mode != 2);
          if (q[i].size() != 0) begin
            e_tv[i] = 1'b1;
            e_td[i*DW +: DW] = q[i][0];
            dm_t[i*DW +: DW] = '1;
          end
        end
        if (top) begin
          if (r == 0 && m_ext != 0) begin
            e_iv[i] = bus.ext_valid[c] && run;
            e_id[i*DW +: DW] = bus.ext_data[c*DW +: DW];
            e_eack[c] = bus.pe_in_ack[i] && run;
          end else begin
            e_iv[i] = run;
          end
        end else begin
          e_iv[i] = bus.pe_out_valid[i-COLS];
          e_id[i*DW +: DW] = bus.pe_out_data[(i-COLS)*DW +: DW];
          e_oack[i-COLS] = bus.pe_in_ack[i];
        end
        if (e_iv[i]) dm_i[i*DW +: DW] = '1;
      end
    end
    for (int k = 0; k < RC; k++) begin
      m_push[k] = bus.pe_out_valid[k] && e_oack[k] && ((((k / COLS) + 1) % m_seg) == 0 || (k / COLS) == ROWS - 1);
      m_pop[k]  = e_tv[k] && bus.tap_ack[k];
      m_pd[k]   = bus.pe_out_data[k*DW +: DW];
    end
    s_rst = rst; s_req = bus.cfg_req; s_rlen = int'(bus.cfg_seg_len); s_rext = bus.cfg_ext_en;
    if (chk_en) begin
      chk("pe_in_valid", W'(bus.pe_in_valid), W'(e_iv));
      chk("pe_in_data", bus.pe_in_data & dm_i, e_id & dm_i);
      chk("pe_out_ack", W'(bus.pe_out_ack), W'(e_oack));
      chk("ext_ack", W'(bus.ext_ack), W'(e_eack));
      chk("tap_valid", W'(bus.tap_valid), W'(e_tv));
      chk("tap_data", bus.tap_data & dm_t, e_td & dm_t);
      chk("cfg_busy", W'(bus.cfg_busy), W'(m_mode != 0));
      chk("cfg_ack", W'(bus.cfg_ack), W'(m_mode == 2));
      chk("cfg_err", W'(bus.cfg_err), W'(m_err));
      chk("seg_len", W'(bus.seg_len), W'(m_seg));
      chk("ext_en", W'(bus.ext_en), W'(m_ext));
    end
  end

  always @(posedge clk) begin
    if (s_rst) begin
      m_seg = ROWS; m_ext = 0; m_mode = 0; m_err = 0;
      for (int k = 0; k < RC; k++) q[k].delete();
    end else begin
      for (int k = 0; k < RC; k++) begin
        if (m_pop[k])  void'(q[k].pop_front());
        if (m_push[k]) q[k].push_back(m_pd[k]);
      end
      m_err = 0;
      case (m_mode)
        0: if (s_req) begin
             if (s_rlen >= 1 && s_rlen <= ROWS) begin
               m_req_seg = s_rlen; m_req_ext = s_rext ? 1 : 0; m_mode = 1;
             end else m_err = 1;
           end
        1: if (s_drain_ok) m_mode = 2;
        default: begin m_seg = m_req_seg; m_ext = m_req_ext; m_mode = 0; end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pe_out_valid = '0; bus.pe_out_data = '0; bus.pe_in_ack = '1;
    bus.ext_valid = '0; bus.ext_data = '0; bus.tap_ack = '0;
    bus.cfg_req = 1'b0; bus.cfg_seg_len = '0; bus.cfg_ext_en = 1'b0;
  endtask

  task automatic drive_row(input int r, input logic [DW-1:0] v);
    for (int c = 0; c < COLS; c++) begin
      bus.pe_out_valid[r*COLS+c] = 1'b1;
      bus.pe_out_data[(r*COLS+c)*DW +: DW] = v;
    end
  endtask

  task automatic request(input int len, input bit ext);
    bus.cfg_req = 1'b1; bus.cfg_seg_len = 3'(len); bus.cfg_ext_en = ext;
    step();
    bus.cfg_req = 1'b0;
  endtask

  logic [COLS*DW-1:0] rep1234;
  logic [RC-1:0]      row_mask;
  int acks, errs;

  initial begin
    rep1234 = {COLS{16'h1234}};
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    #1;
    chk("rst_pe_in_valid", W'(bus.pe_in_valid), '0);
    chk("rst_tap_valid", W'(bus.tap_valid), '0);
    chk("rst_busy", W'(bus.cfg_busy), '0);
    chk("rst_seg_len", W'(bus.seg_len), W'(6));
    chk("rst_ext_ack", W'(bus.ext_ack), '0);
    step();
    rst = 1'b0;

    // Default single segment: zeros into row 0, taps on row 5 only
    #1;
    chk("t1_row0_valid", W'(bus.pe_in_valid), W'(7'h7f));
    chk("t1_out_ack", W'(bus.pe_out_ack), W'({RC{1'b1}}));
    drive_row(5, '0);
    step();
    bus.pe_out_valid = '0;
    #1;
    chk("t1_tap_valid", W'(bus.tap_valid), W'(7'h7f) << 35);
    chk("t1_tap_data", bus.tap_data, '0);

    // Reconfigure to seg_len 3 with ext while row-5 FIFOs hold two entries
    drive_row(5, 16'h00aa);
    step();
    bus.pe_out_valid = '0;
    request(3, 1'b1);
    #1;
    chk("t2_busy", W'(bus.cfg_busy), W'(1));
    request(2, 1'b0);
    repeat (3) step();
    chk("t2_hold_busy", W'(bus.cfg_busy), W'(1));
    chk("t2_no_err", W'(bus.cfg_err), '0);
    for (int c = 0; c < COLS; c++) bus.tap_ack[35+c] = 1'b1;
    acks = 0; errs = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.cfg_ack) acks++;
      if (bus.cfg_err) errs++;
    end
    bus.tap_ack = '0;
    chk("t2_ack_count", W'(acks), W'(1));
    chk("t2_err_count", W'(errs), '0);
    chk("t2_seg_len", W'(bus.seg_len), W'(3));
    chk("t2_ext_en", W'(bus.ext_en), W'(1));
    bus.ext_valid = '1; bus.ext_data = rep1234;
    #1;
    chk("t2_row0_data", W'(bus.pe_in_data[COLS*DW-1:0]), W'(rep1234));
    chk("t2_ext_ack", W'(bus.ext_ack), W'(7'h7f));
    chk("t2_row3_valid", W'(bus.pe_in_valid[3*COLS +: COLS]), W'(7'h7f));
    chk("t2_row3_data", W'(bus.pe_in_data[3*COLS*DW +: COLS*DW]), '0);
    drive_row(2, 16'h1234);
    step();
    bus.pe_out_valid = '0; bus.ext_valid = '0;
    #1;
    chk("t2_tap_valid", W'(bus.tap_valid), W'(7'h7f) << 14);
    chk("t2_tap2_data", W'(bus.tap_data[2*COLS*DW +: COLS*DW]), W'(rep1234));
    for (int c = 0; c < COLS; c++) bus.tap_ack[14+c] = 1'b1;
    step();
    bus.tap_ack = '0;

    // Backpressure on tap (5,0)
    bus.pe_out_valid[35] = 1'b1; bus.pe_out_data[35*DW +: DW] = 16'h000a;
    #1; chk("t3_ack_a", W'(bus.pe_out_ack[35]), W'(1));
    step(); bus.pe_out_data[35*DW +: DW] = 16'h000b;
    #1; chk("t3_ack_b", W'(bus.pe_out_ack[35]), W'(1));
    step(); bus.pe_out_data[35*DW +: DW] = 16'h000c;
    #1; chk("t3_ack_c", W'(bus.pe_out_ack[35]), '0);
    step();
    chk("t3_head_a", W'(bus.tap_data[35*DW +: DW]), W'(16'h000a));
    bus.tap_ack[35] = 1'b1; bus.pe_out_data[35*DW +: DW] = 16'h000d;
    #1; chk("t3_full_ack", W'(bus.pe_out_ack[35]), '0);
    step();
    chk("t3_head_b", W'(bus.tap_data[35*DW +: DW]), W'(16'h000b));
    chk("t3_ack_d", W'(bus.pe_out_ack[35]), W'(1));
    step();
    bus.tap_ack = '0; bus.pe_out_valid = '0;
    #1;
    chk("t3_head_d", W'(bus.tap_data[35*DW +: DW]), W'(16'h000d));
    bus.tap_ack[35] = 1'b1;
    step();
    bus.tap_ack = '0;

    // Illegal segment lengths
    request(0, 1'b0);
    chk("t4_err0", W'(bus.cfg_err), W'(1));
    chk("t4_busy0", W'(bus.cfg_busy), '0);
    step();
    chk("t4_err0_clr", W'(bus.cfg_err), '0);
    request(7, 1'b0);
    chk("t4_err7", W'(bus.cfg_err), W'(1));
    chk("t4_seg_len", W'(bus.seg_len), W'(3));

    // Reset in DRAIN with full FIFOs
    drive_row(2, 16'h0055); drive_row(5, 16'h0066);
    step(); step();
    bus.pe_out_valid = '0;
    request(2, 1'b1);
    step();
    chk("t6_busy", W'(bus.cfg_busy), W'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_seg_len", W'(bus.seg_len), W'(6));
    chk("t6_ext_en", W'(bus.ext_en), '0);
    chk("t6_tap_valid", W'(bus.tap_valid), '0);
    chk("t6_busy_clr", W'(bus.cfg_busy), '0);

    // Randomized traffic and reconfiguration
    for (int k = 0; k < 2000; k++) begin
      row_mask = RC'({$urandom, $urandom});
      bus.pe_out_valid = (bus.cfg_busy && $urandom_range(0, 3) != 0) ? '0 : row_mask;
      for (int i = 0; i < RC; i++) bus.pe_out_data[i*DW +: DW] = DW'($urandom);
      bus.pe_in_ack = RC'({$urandom, $urandom});
      bus.tap_ack   = RC'({$urandom, $urandom});
      bus.ext_valid = COLS'($urandom);
      for (int c = 0; c < COLS; c++) bus.ext_data[c*DW +: DW] = DW'($urandom);
      bus.cfg_req     = ($urandom_range(0, 15) == 0);
      bus.cfg_seg_len = 3'($urandom_range(0, 7));
      bus.cfg_ext_en  = 1'($urandom);
      step();
    end
    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
